// File: rtl/regfile_dump_reader.sv
// Register-file dump reader: walks registers in pairs and streams them out on valid/ready.
// Optional XOR checksum of accepted beats is enabled by defining REGDUMP_CHECKSUM_EN.
module regfile_dump_reader #(
  parameter int NREGS     = 32,
  parameter int AW        = 5,
  parameter int DW        = 32,
  parameter int FIRST_REG = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic [AW-1:0] rs_addr,
  output logic [AW-1:0] rt_addr,
  input  logic [DW-1:0] rs_data,
  input  logic [DW-1:0] rt_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [AW-1:0] out_idx,
  output logic          out_last,
  output logic          done,
  output logic [DW-1:0] csum
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_OUT0,
    S_OUT1,
    S_FIN
  } state_t;

  localparam int PW = AW + 1;
  localparam logic [AW:0] L_N     = PW'(NREGS);
  localparam logic [AW:0] L_FIRST = PW'(FIRST_REG);

  state_t        r_state;
  logic [AW:0]   r_ptr;
  logic [DW-1:0] r_buf0;
  logic [DW-1:0] r_buf1;
  logic          r_busy;
  logic          r_valid;
  logic          r_last;
  logic          r_done;
  logic [AW-1:0] r_rs_addr;
  logic [AW-1:0] r_rt_addr;
  logic [DW-1:0] r_data;
  logic [AW-1:0] r_idx;

  state_t        w_nstate;
  logic [AW:0]   w_nptr;
  logic [AW:0]   w_p1;
  logic [AW:0]   w_p2;
  logic [AW:0]   w_np1;
  logic [AW:0]   w_np2;
  logic [DW-1:0] w_nbuf0;
  logic [DW-1:0] w_nbuf1;
  logic          w_hs;

  always_comb begin
    w_p1     = r_ptr + 1'b1;
    w_p2     = r_ptr + 2'd2;
    w_hs     = r_valid & out_ready;
    w_nstate = r_state;
    w_nptr   = r_ptr;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_nptr   = L_FIRST;
          w_nstate = S_READ;
        end
      end
      S_READ: w_nstate = S_OUT0;
      S_OUT0: begin
        if (w_hs) w_nstate = (w_p1 < L_N) ? S_OUT1 : S_FIN;
      end
      S_OUT1: begin
        if (w_hs) begin
          w_nptr   = w_p2;
          w_nstate = (w_p2 >= L_N) ? S_FIN : S_READ;
        end
      end
      S_FIN:   w_nstate = S_IDLE;
      default: w_nstate = S_IDLE;
    endcase
    w_np1   = w_nptr + 1'b1;
    w_np2   = w_nptr + 2'd2;
    w_nbuf0 = (r_state == S_READ) ? rs_data : r_buf0;
    w_nbuf1 = (r_state == S_READ) ? rt_data : r_buf1;
  end

  // Outputs are registered from next-state values so they line up with the state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_ptr     <= '0;
      r_buf0    <= '0;
      r_buf1    <= '0;
      r_busy    <= 1'b0;
      r_valid   <= 1'b0;
      r_last    <= 1'b0;
      r_done    <= 1'b0;
      r_rs_addr <= '0;
      r_rt_addr <= '0;
      r_data    <= '0;
      r_idx     <= '0;
    end else begin
      r_state <= w_nstate;
      r_ptr   <= w_nptr;
      r_buf0  <= w_nbuf0;
      r_buf1  <= w_nbuf1;
      r_busy  <= (w_nstate != S_IDLE);
      r_valid <= (w_nstate == S_OUT0) || (w_nstate == S_OUT1);
      r_done  <= (w_nstate == S_FIN);
      if (w_nstate == S_READ) begin
        r_rs_addr <= w_nptr[AW-1:0];
        r_rt_addr <= (w_np1 < L_N) ? w_np1[AW-1:0] : w_nptr[AW-1:0];
      end else begin
        r_rs_addr <= '0;
        r_rt_addr <= '0;
      end
      unique case (w_nstate)
        S_OUT0: begin
          r_data <= w_nbuf0;
          r_idx  <= w_nptr[AW-1:0];
          r_last <= (w_np1 >= L_N);
        end
        S_OUT1: begin
          r_data <= w_nbuf1;
          r_idx  <= w_np1[AW-1:0];
          r_last <= (w_np2 >= L_N);
        end
        default: begin
          r_data <= '0;
          r_idx  <= '0;
          r_last <= 1'b0;
        end
      endcase
    end
  end

`ifdef REGDUMP_CHECKSUM_EN
  logic [DW-1:0] r_csum;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_csum <= '0;
    end else if ((r_state == S_IDLE) && start) begin
      r_csum <= '0;
    end else if (w_hs) begin
      r_csum <= r_csum ^ r_data;
    end
  end

  assign csum = r_csum;
`else
  assign csum = '0;
`endif

  assign busy      = r_busy;
  assign rs_addr   = r_rs_addr;
  assign rt_addr   = r_rt_addr;
  assign out_valid = r_valid;
  assign out_data  = r_data;
  assign out_idx   = r_idx;
  assign out_last  = r_last;
  assign done      = r_done;

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Directed bench for regfile_dump_reader: full dumps, backpressure, restart,
// abort by reset, post-capture write, and a narrowed FIRST_REG/NREGS instance.
module tb_regfile_dump_reader;

  localparam int AW = 5;
  localparam int DW = 32;
`ifdef REGDUMP_CHECKSUM_EN
  localparam bit CS_EN = 1'b1;
`else
  localparam bit CS_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          busy;
  logic [AW-1:0] rs_addr;
  logic [AW-1:0] rt_addr;
  logic [DW-1:0] rs_data;
  logic [DW-1:0] rt_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic [AW-1:0] out_idx;
  logic          out_last;
  logic          done;
  logic [DW-1:0] csum;

  logic          start_b = 1'b0;
  logic          b_busy;
  logic [AW-1:0] b_rs_addr;
  logic [AW-1:0] b_rt_addr;
  logic [DW-1:0] b_rs_data;
  logic [DW-1:0] b_rt_data;
  logic          b_valid;
  logic          b_ready = 1'b0;
  logic [DW-1:0] b_data;
  logic [AW-1:0] b_idx;
  logic          b_last;
  logic          b_done;
  logic [DW-1:0] b_csum;

  logic [DW-1:0] rf   [32];
  logic [DW-1:0] rf_b [8];
  logic [DW-1:0] exp_a[32];
  logic [DW-1:0] cs_model;

  int n_checks = 0;
  int n_err    = 0;

  assign rs_data   = rf[rs_addr];
  assign rt_data   = rf[rt_addr];
  assign b_rs_data = rf_b[b_rs_addr[2:0]];
  assign b_rt_data = rf_b[b_rt_addr[2:0]];

  always #5 clk = ~clk;

  regfile_dump_reader #(.NREGS(32), .AW(AW), .DW(DW), .FIRST_REG(0)) u_dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy),
    .rs_addr(rs_addr), .rt_addr(rt_addr),
    .rs_data(rs_data), .rt_data(rt_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_idx(out_idx), .out_last(out_last),
    .done(done), .csum(csum)
  );

  regfile_dump_reader #(.NREGS(8), .AW(AW), .DW(DW), .FIRST_REG(3)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b), .busy(b_busy),
    .rs_addr(b_rs_addr), .rt_addr(b_rt_addr),
    .rs_data(b_rs_data), .rt_data(b_rt_data),
    .out_valid(b_valid), .out_ready(b_ready),
    .out_data(b_data), .out_idx(b_idx), .out_last(b_last),
    .done(b_done), .csum(b_csum)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // pat 0: ready always high; pat 1: stall the first valid cycle of every beat.
  task automatic dump_a(input int pat, input int abort_at,
                        input bit inj_start, input bit wr10,
                        output int cycles);
    int            beats;
    bit            stl;
    bit            injected;
    bit            written;
    logic [DW-1:0] pdata;
    logic [AW-1:0] pidx;
    logic          rdy;
    beats = 0; stl = 0; injected = 0; written = 0;
    pdata = '0; pidx = '0; cs_model = '0; cycles = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("valid_in_read", out_valid, 0);
    while (cycles < 200) begin
      start = 1'b0;
      if (abort_at > 0 && beats == abort_at) begin
        rst = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_valid", out_valid, 0);
        chk("abort_done", done, 0);
        chk("abort_csum", csum, 0);
        rst = 1'b1;
        return;
      end
      if (done) break;
      if (!out_valid) begin
        rdy = 1'b1;
        chk("rs_addr", rs_addr, beats);
        chk("rt_addr", rt_addr, beats + 1);
      end else begin
        rdy = (pat == 0) ? 1'b1 : stl;
        if (stl) begin
          chk("hold_data", out_data, pdata);
          chk("hold_idx", out_idx, pidx);
        end
        if (inj_start && !injected && out_idx[0]) begin
          start = 1'b1;
          injected = 1'b1;
        end
        if (wr10 && !written && out_idx == 5'd10) begin
          rf[10] = 32'hDEAD;
          written = 1'b1;
        end
        if (rdy) begin
          chk("beat_idx", out_idx, beats);
          chk("beat_data", out_data, exp_a[beats]);
          chk("beat_last", out_last, (beats == 31));
          cs_model = cs_model ^ out_data;
          beats++;
        end
        stl = !rdy;
        pdata = out_data;
        pidx = out_idx;
      end
      out_ready = rdy;
      tick();
      cycles++;
    end
    out_ready = 1'b0;
    chk("done_pulse", done, 1);
    chk("beat_count", beats, 32);
    chk("fin_busy", busy, 1);
    chk("fin_valid", out_valid, 0);
    chk("csum", csum, CS_EN ? cs_model : 32'h0);
    tick();
    chk("idle_done", done, 0);
    chk("idle_busy", busy, 0);
    tick();
    chk("no_restart", busy, 0);
  endtask

  initial begin
    int            cyc;
    int            nb;
    int            bcyc;
    logic [AW-1:0] last_rt;
    for (int i = 0; i < 32; i++) begin
      rf[i] = 32'h100 + i;
      exp_a[i] = 32'h100 + i;
    end
    for (int i = 0; i < 8; i++) rf_b[i] = 32'hA0 + i;

    #12;
    chk("rst_busy", busy, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_last", out_last, 0);
    chk("rst_addr", {rs_addr, rt_addr}, 0);
    chk("rst_out", {out_data, 3'b0, out_idx}, 0);
    chk("rst_csum", csum, 0);
    rst = 1'b1;
    tick();

    dump_a(0, 0, 0, 0, cyc);
    chk("full_cycles", cyc, 48);
    dump_a(1, 0, 0, 0, cyc);
    chk("bp_cycles", cyc, 80);
    dump_a(0, 0, 1, 0, cyc);
    chk("inj_cycles", cyc, 48);
    dump_a(0, 5, 0, 0, cyc);
    tick();
    dump_a(0, 0, 0, 0, cyc);
    dump_a(0, 0, 0, 1, cyc);
    exp_a[10] = 32'hDEAD;
    dump_a(0, 0, 0, 0, cyc);

    nb = 0; bcyc = 0; last_rt = '0;
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    while (!b_done && bcyc < 100) begin
      b_ready = 1'b1;
      if (b_busy && !b_valid) last_rt = b_rt_addr;
      if (b_valid) begin
        chk("b_idx", b_idx, 3 + nb);
        chk("b_data", b_data, 32'hA3 + nb);
        chk("b_last", b_last, (nb == 4));
        nb++;
      end
      tick();
      bcyc++;
    end
    b_ready = 1'b0;
    chk("b_done", b_done, 1);
    chk("b_handshakes", nb, 5);
    chk("b_final_rt", last_rt, 7);
    chk("b_csum", b_csum, CS_EN ? 32'hA3 : 32'h0);
    tick();
    chk("b_idle", b_busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_dump_reader.md
Name: regfile_dump_reader

Overview:
- Sequential read-out engine for the MIPS register file. It owns both register-file read ports while busy and walks registers FIRST_REG..NREGS-1, two per read cycle (rs = even, rt = odd).
- Streams each register value out on a valid/ready interface, tagged with its index.
- Used for debug dump and end-of-program result checking; the complement of the testbench write path that loads the register file.

Parameters:
- NREGS, 32, number of registers walked (upper bound exclusive).
- AW, 5, register address width.
- DW, 32, register data width.
- FIRST_REG, 0, first register index dumped; must be < NREGS.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request to begin a dump; sampled in IDLE only.
- busy  output  1  high from the cycle after start is accepted until return to IDLE; CPU must not rely on rs/rt while high.
- rs_addr  output  AW  register-file read address A (even slot).
- rt_addr  output  AW  register-file read address B (odd slot).
- rs_data  input  DW  register-file read data A; combinational from rs_addr.
- rt_data  input  DW  register-file read data B; combinational from rt_addr.
- out_valid  output  1  beat valid.
- out_ready  input  1  downstream accepts beat.
- out_data  output  DW  register value.
- out_idx  output  AW  register index of out_data.
- out_last  output  1  high with the final beat.
- done  output  1  one-cycle pulse after the final beat is accepted.
- csum  output  DW  XOR checksum of all accepted beats (see Optional Feature).

Behaviour:
- Reset (rst low, asynchronous):
  - state = IDLE.
  - ptr, buf0, buf1, csum = 0.
  - busy, out_valid, out_last, done = 0.
  - rs_addr, rt_addr, out_data, out_idx = 0.
  - Reset mid-dump aborts immediately; no further beats are produced.
- State IDLE:
  - rs_addr = rt_addr = 0.
  - On start = 1: ptr <= FIRST_REG, csum <= 0, go to READ.
- State READ (exactly 1 cycle):
  - busy = 1; rs_addr = ptr, rt_addr = ptr+1. If ptr+1 >= NREGS, rt_addr = ptr.
  - At the clock edge: buf0 <= rs_data, buf1 <= rt_data, go to OUT0.
- State OUT0:
  - out_valid = 1, out_data = buf0, out_idx = ptr.
  - out_last = 1 iff ptr+1 >= NREGS.
  - Handshake (out_valid & out_ready): go to OUT1 if ptr+1 < NREGS, else go to FIN.
- State OUT1:
  - out_valid = 1, out_data = buf1, out_idx = ptr+1.
  - out_last = 1 iff ptr+2 >= NREGS.
  - Handshake: ptr <= ptr+2; go to FIN if ptr+2 >= NREGS, else go to READ.
- State FIN (1 cycle):
  - done = 1, busy = 1, out_valid = 0; next state is IDLE.
- Handshake rules:
  - out_data, out_idx and out_last are held stable while out_valid = 1 and out_ready = 0.
  - out_valid never drops without a handshake.
  - out_ready is ignored when out_valid = 0.
- start is ignored outside IDLE, including in FIN. Back-to-back dumps therefore need start in or after the first IDLE cycle.
- Throughput and latency:
  - Each pair costs 1 READ cycle plus 2 beats, so best case is 3 cycles per 2 registers.
  - Default full dump: 32 beats in 48 cycles with out_ready held high, plus FIN.
  - First beat is valid 2 cycles after the start edge.
- Register data is captured in READ only. Writes to the register file after capture are not reflected in the beats already buffered.
- Index arithmetic: ptr is AW+1 bits wide internally so ptr+2 compares correctly at NREGS = 2^AW; out_idx carries the low AW bits.
- csum updates on each handshake: csum <= csum ^ out_data. csum is stable from FIN until the next accepted start.

Optional Feature:
- Macro: REGDUMP_CHECKSUM_EN.
- Defined: csum behaves as above.
- Undefined: the XOR logic and register are removed and csum is driven constant 0. All other behaviour is identical.

Test Plan:
- Preload r0..r31 with value = 0x100 + index, then pulse start with out_ready = 1. Expect 32 beats, idx 0..31, data 0x100..0x11F, out_last only on idx 31, done one cycle after, busy low the cycle after done. With REGDUMP_CHECKSUM_EN, csum = 0x00000000 (the XOR of 0x100..0x11F).
- Backpressure: toggle out_ready 1/0 every cycle. Expect identical beat sequence; data and idx unchanged across every stall cycle; total time 64 beat cycles + 16 READ + FIN.
- FIRST_REG = 3, NREGS = 8, r3..r7 = 0xA3..0xA7. Expect beats idx 3,4,5,6,7; out_last on idx 7; rt_addr = 7 on the final READ; 5 handshakes total.
- Start pulse during OUT1 of an active dump. Expect it ignored: the sequence is unchanged and exactly one done pulse.
- Assert rst low after 5 beats accepted. Expect busy, out_valid, done = 0 asynchronously. A new start then restarts at FIRST_REG with csum cleared.
- Write r10 = 0xDEAD while the reader is in OUT0 of pair (10,11), i.e. after capture. Expect beat idx 10 carries the pre-write value; a second dump shows 0xDEAD.
